// File: rtl/fixed_to_float.sv
// Signed fixed-point (FRAC_BITS fractional bits) to IEEE-754 single converter, strobe/ack handshake.
// Define FIXED_TO_FLOAT_RNE_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module fixed_to_float #(
  parameter int FRAC_BITS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  typedef enum logic [2:0] {
    get_a,
    unpack,
    special_cases,
    normalise,
    round,
    pack,
    put_z
  } state_t;

  localparam logic [8:0] EXP_BIAS = 9'(127 + 31 - FRAC_BITS);

  state_t      state;
  logic [31:0] a;
  logic [31:0] a_m;
  logic [8:0]  a_e;
  logic        a_s;
  logic [22:0] mant;
  logic [31:0] z;

  // 33-bit negate so that the most negative input yields magnitude 2^31
  logic [32:0] a_neg;
  assign a_neg = 33'd0 - {a[31], a};

  logic round_up;
`ifdef FIXED_TO_FLOAT_RNE_EN
  assign round_up = a_m[7] && (a_m[6] || (|a_m[5:0]) || a_m[8]);
`else
  assign round_up = 1'b0;
`endif

  logic [23:0] mant_sum;
  assign mant_sum = {1'b0, a_m[30:8]} + {23'd0, round_up};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= get_a;
      input_a_ack  <= 1'b0;
      output_z_stb <= 1'b0;
      output_z     <= 32'd0;
      a            <= 32'd0;
      a_m          <= 32'd0;
      a_e          <= 9'd0;
      a_s          <= 1'b0;
      mant         <= 23'd0;
      z            <= 32'd0;
    end else begin
      case (state)
        get_a: begin
          if (input_a_ack && input_a_stb) begin
            a           <= input_a;
            input_a_ack <= 1'b0;
            state       <= unpack;
          end else begin
            input_a_ack <= 1'b1;
          end
        end
        unpack: begin
          a_s   <= a[31];
          a_m   <= a[31] ? a_neg[31:0] : a;
          a_e   <= EXP_BIAS;
          state <= special_cases;
        end
        special_cases: begin
          if (a_m == 32'd0) begin
            z     <= 32'd0;
            state <= put_z;
          end else begin
            state <= normalise;
          end
        end
        normalise: begin
          if (a_m[31]) begin
            state <= round;
          end else begin
            a_m <= a_m << 1;
            a_e <= a_e - 9'd1;
          end
        end
        round: begin
          // A carry out of the mantissa leaves the fraction at zero and bumps the exponent
          mant <= mant_sum[22:0];
          if (mant_sum[23]) a_e <= a_e + 9'd1;
          state <= pack;
        end
        pack: begin
          z     <= {a_s, a_e[7:0], mant};
          state <= put_z;
        end
        put_z: begin
          if (!output_z_stb) begin
            output_z_stb <= 1'b1;
            output_z     <= z;
          end else if (output_z_ack) begin
            output_z_stb <= 1'b0;
            state        <= get_a;
          end
        end
        default: state <= get_a;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_to_float.sv
// Self-checking bench for fixed_to_float: directed and random operands against an arithmetic reference.
// Build with the same FIXED_TO_FLOAT_RNE_EN setting as the RTL.
module tb_fixed_to_float;

  localparam int FRAC_BITS = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] input_a = 32'd0;
  logic        input_a_stb = 1'b0;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack = 1'b0;

  int checks = 0;
  int failures = 0;

  fixed_to_float #(.FRAC_BITS(FRAC_BITS)) dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: exact value scaled by 2^-FRAC_BITS, rounded with integer arithmetic
  function automatic logic [31:0] ref_float(input logic [31:0] x, output int lat);
    longint m, q, rem, half;
    int p, e, sh;
    logic s;
    s = x[31];
    m = longint'({32'd0, x});
    if (s) m = (64'sd1 <<< 32) - m;
    if (m == 0) begin
      lat = 3;
      return 32'd0;
    end
    p = 31;
    while (((m >>> p) & 1) == 0) p--;
    lat = 6 + (31 - p);
    e = 127 + p - FRAC_BITS;
    if (p <= 23) begin
      q = m <<< (23 - p);
    end else begin
      sh   = p - 23;
      q    = m >>> sh;
      rem  = m - (q <<< sh);
      half = 64'sd1 <<< (sh - 1);
`ifdef FIXED_TO_FLOAT_RNE_EN
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (64'sd1 <<< 24)) begin
        q = q >>> 1;
        e++;
      end
`endif
    end
    return {s, 8'(e), 23'(q)};
  endfunction

  task automatic do_conv(input logic [31:0] x, input int hold, input bit early_ack);
    logic [31:0] exp_z;
    int exp_lat, lat, w;
    exp_z = ref_float(x, exp_lat);
    @(negedge clk);
    input_a      = x;
    input_a_stb  = 1'b1;
    output_z_ack = early_ack;
    w = 0;
    while (!input_a_ack && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("accept_ready", 64'(input_a_ack), 64'd1);
    @(posedge clk);
    #1;
    // Keep a junk strobe up during the conversion; it must not be captured
    input_a = ~x;
    lat = 0;
    while (!output_z_stb && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    input_a_stb = 1'b0;
    check("latency", 64'(lat), 64'(exp_lat));
    check("result", 64'(output_z), 64'(exp_z));
    $display("xfer in=%h out=%h exp=%h lat=%0d hold=%0d early_ack=%0d",
             x, output_z, exp_z, lat, hold, early_ack);
    if (early_ack) begin
      @(posedge clk);
      #1;
      check("early_ack_drop", {62'd0, output_z_stb, input_a_ack}, 64'd0);
      output_z_ack = 1'b0;
      @(posedge clk);
      #1;
      check("ack_after_dead", 64'(input_a_ack), 64'd1);
    end else begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        check("stall_hold", {30'd0, output_z_stb, input_a_ack, output_z},
              {30'd0, 1'b1, 1'b0, exp_z});
      end
      @(negedge clk);
      output_z_ack = 1'b1;
      @(posedge clk);
      #1;
      check("stb_drop", {62'd0, output_z_stb, input_a_ack}, 64'd0);
      output_z_ack = 1'b0;
      @(posedge clk);
      #1;
      check("ack_after_dead", 64'(input_a_ack), 64'd1);
    end
  endtask

  initial begin
    int stale, w;
    logic [31:0] r;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {31'd0, input_a_ack, output_z_stb, output_z}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("ack_after_reset", 64'(input_a_ack), 64'd1);

    // Directed operands
    do_conv(32'h0001_0000, 0, 1'b0);
    do_conv(32'h0001_8000, 10, 1'b0);
    do_conv(32'hFFFF_0000, 1, 1'b0);
    do_conv(32'h8000_0000, 0, 1'b1);
    do_conv(32'h0000_0000, 2, 1'b0);
    do_conv(32'h0000_0001, 0, 1'b0);
    do_conv(32'h7FFF_FFFF, 0, 1'b1);
    do_conv(32'h0100_0001, 0, 1'b0);
    do_conv(32'h0100_0180, 0, 1'b0);
    do_conv(32'hFFFF_FFFF, 0, 1'b0);

    // Reset mid-normalise discards the conversion
    @(negedge clk);
    input_a     = 32'h0001_0000;
    input_a_stb = 1'b1;
    w = 0;
    while (!input_a_ack && w < 100) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    input_a_stb = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid_reset_state", {31'd0, input_a_ack, output_z_stb, output_z}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    stale = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (output_z_stb) stale++;
    end
    check("no_stale_result", 64'(stale), 64'd0);
    do_conv(32'h0001_0000, 0, 1'b0);

    // Random operands spread over all leading-zero counts and both signs
    for (int n = 0; n < 40; n++) begin
      r = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) r = 32'd0 - r;
      do_conv(r, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
